// File: rtl/mmio_csr_spm_bridge.sv
// MMIO slave that splits the core load/store window into a local CSR file
// and a banked scratchpad reached over a valid/ready port.
module mmio_csr_spm_bridge #(
    parameter int DATA_W            = 32,
    parameter int ADDR_W            = 16,
    parameter int NUM_RFILE         = 2,
    parameter int NUM_WFILE         = 3,
    parameter int CSR_SELECT_BITIDX = 10,
    parameter int SPM_BANK_SIZE     = 512,
    parameter int NUM_SPM_BANKS     = 2,
    localparam int STRB_W = DATA_W / 8,
    localparam int SA_W   = $clog2(SPM_BANK_SIZE),
    localparam int BB     = $clog2(NUM_SPM_BANKS),
    localparam int BANK_W = (BB > 0) ? BB : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    input  logic [STRB_W-1:0]             req_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    input  logic [NUM_RFILE*DATA_W-1:0]   rfile_i,
    output logic [NUM_WFILE*DATA_W-1:0]   wfile_o,
    output logic [NUM_WFILE-1:0]          wfile_wr_o,
    output logic                          spm_req_valid,
    input  logic                          spm_req_ready,
    output logic                          spm_we,
    output logic [DATA_W-1:0]             spm_wdata,
    output logic [STRB_W-1:0]             spm_wstrb,
    output logic [BANK_W-1:0]             spm_bank,
    output logic [SA_W-1:0]               spm_addr,
    input  logic                          spm_rsp_valid,
    input  logic [DATA_W-1:0]             spm_rsp_rdata
);

    localparam int SPAN = (NUM_RFILE > NUM_WFILE) ? NUM_RFILE : NUM_WFILE;
    localparam int CW   = $clog2(2 * SPAN);
    localparam int WW   = ADDR_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        CSR_RSP,
        SPM_REQ,
        SPM_WAIT,
        RSP
    } state_t;

    state_t                             state_q;
    logic                               req_ready_q;
    logic                               rsp_valid_q;
    logic                               rsp_err_q;
    logic [DATA_W-1:0]                  rsp_rdata_q;
    logic [NUM_WFILE-1:0][DATA_W-1:0]   wfile_q;
    logic [NUM_WFILE-1:0]               wfile_wr_q;
    logic                               spm_req_valid_q;
    logic                               spm_we_q;
    logic [DATA_W-1:0]                  spm_wdata_q;
    logic [STRB_W-1:0]                  spm_wstrb_q;
    logic [BANK_W-1:0]                  spm_bank_q;
    logic [SA_W-1:0]                    spm_addr_q;
    logic                               we_q;
    logic [DATA_W-1:0]                  wdata_q;
    logic [STRB_W-1:0]                  wstrb_q;
    logic [CW-1:0]                      cidx_q;
    logic                               csr_wr_q;
    logic [DATA_W-1:0]                  data_q;

    logic [WW-1:0]     w;
    logic [CW-1:0]     c;
    logic [31:0]       c32;
    logic [31:0]       w32;
    logic              dec_err;
    logic              dec_spm;
    logic              dec_csr_wr;
    logic [DATA_W-1:0] dec_data;

    // Request decode; RO data is captured here so it reflects rfile_i at accept.
    always_comb begin
        w          = req_addr[ADDR_W-1:2];
        c          = w[CW-1:0];
        c32        = 32'(c);
        w32        = 32'(w);
        dec_err    = 1'b0;
        dec_spm    = 1'b0;
        dec_csr_wr = 1'b0;
        dec_data   = '0;
        if (req_addr[1:0] != 2'b00) begin
            dec_err = 1'b1;
        end else if (!req_addr[CSR_SELECT_BITIDX]) begin
            if (w32 >= 32'(SPM_BANK_SIZE * NUM_SPM_BANKS)) begin
                dec_err = 1'b1;
            end else begin
                dec_spm = 1'b1;
            end
        end else if (c32 < 32'(NUM_WFILE)) begin
            dec_csr_wr = req_we && (req_wstrb != '0);
            for (int i = 0; i < NUM_WFILE; i++) begin
                if (c32 == 32'(i)) begin
                    dec_data = wfile_q[i];
                end
            end
        end else if (c32 >= 32'(SPAN) &&
                     c32 < 32'(SPAN + NUM_RFILE) && !req_we) begin
            for (int i = 0; i < NUM_RFILE; i++) begin
                if (c32 == 32'(SPAN + i)) begin
                    dec_data = rfile_i[i*DATA_W +: DATA_W];
                end
            end
        end else begin
            dec_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_rdata_q     <= '0;
            wfile_q         <= '0;
            wfile_wr_q      <= '0;
            spm_req_valid_q <= 1'b0;
            spm_we_q        <= 1'b0;
            spm_wdata_q     <= '0;
            spm_wstrb_q     <= '0;
            spm_bank_q      <= '0;
            spm_addr_q      <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            cidx_q          <= '0;
            csr_wr_q        <= 1'b0;
            data_q          <= '0;
        end else begin
            wfile_wr_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        wdata_q     <= req_wdata;
                        wstrb_q     <= req_wstrb;
                        cidx_q      <= c;
                        csr_wr_q    <= dec_csr_wr;
                        data_q      <= dec_data;
                        if (dec_err) begin
                            state_q     <= RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (dec_spm) begin
                            state_q         <= SPM_REQ;
                            spm_req_valid_q <= 1'b1;
                            spm_we_q        <= req_we;
                            spm_wdata_q     <= req_wdata;
                            spm_wstrb_q     <= req_wstrb;
                            spm_bank_q      <= w[SA_W +: BANK_W];
                            spm_addr_q      <= w[SA_W-1:0];
                        end else begin
                            state_q <= CSR_RSP;
                        end
                    end
                end
                CSR_RSP: begin
                    state_q     <= RSP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= we_q ? '0 : data_q;
                    if (csr_wr_q) begin
                        for (int i = 0; i < NUM_WFILE; i++) begin
                            if (32'(cidx_q) == 32'(i)) begin
                                wfile_wr_q[i] <= 1'b1;
                                for (int b = 0; b < STRB_W; b++) begin
                                    if (wstrb_q[b]) begin
                                        wfile_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
                                    end
                                end
                            end
                        end
                    end
                end
                SPM_REQ: begin
                    if (spm_req_ready) begin
                        spm_req_valid_q <= 1'b0;
                        state_q         <= SPM_WAIT;
                    end
                end
                SPM_WAIT: begin
                    if (spm_rsp_valid) begin
                        state_q     <= RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? '0 : spm_rsp_rdata;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign wfile_o       = wfile_q;
    assign wfile_wr_o    = wfile_wr_q;
    assign spm_req_valid = spm_req_valid_q;
    assign spm_we        = spm_we_q;
    assign spm_wdata     = spm_wdata_q;
    assign spm_wstrb     = spm_wstrb_q;
    assign spm_bank      = spm_bank_q;
    assign spm_addr      = spm_addr_q;

endmodule

// File: tb/tb_mmio_csr_spm_bridge.sv
// Directed bench for mmio_csr_spm_bridge: vector table of single
// transactions plus a reset-in-flight sequence.
module tb_mmio_csr_spm_bridge;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [63:0] rfile_i;
    logic [95:0] wfile_o;
    logic [2:0]  wfile_wr_o;
    logic        spm_req_valid;
    logic        spm_req_ready;
    logic        spm_we;
    logic [31:0] spm_wdata;
    logic [3:0]  spm_wstrb;
    logic [0:0]  spm_bank;
    logic [8:0]  spm_addr;
    logic        spm_rsp_valid;
    logic [31:0] spm_rsp_rdata;

    localparam logic [31:0] RO1 = 32'h1357_9BDF;

    mmio_csr_spm_bridge dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .rfile_i       (rfile_i),
        .wfile_o       (wfile_o),
        .wfile_wr_o    (wfile_wr_o),
        .spm_req_valid (spm_req_valid),
        .spm_req_ready (spm_req_ready),
        .spm_we        (spm_we),
        .spm_wdata     (spm_wdata),
        .spm_wstrb     (spm_wstrb),
        .spm_bank      (spm_bank),
        .spm_addr      (spm_addr),
        .spm_rsp_valid (spm_rsp_valid),
        .spm_rsp_rdata (spm_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] ro0;
        int          hold;
        int          stall;
        logic [31:0] spm_rd;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic        exp_spm;
        logic        exp_bank;
        logic [8:0]  exp_saddr;
        logic [2:0]  exp_pulse;
        logic [95:0] exp_wf;
    } vec_t;

    int checks;
    int fails;
    vec_t vecs[16];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic we, input logic [15:0] a, input logic [31:0] wd,
        input logic [3:0] ws, input logic [31:0] ro0, input int hold,
        input int stall, input logic [31:0] srd, input logic err,
        input logic [31:0] rd, input int lat, input logic spm,
        input logic b, input logic [8:0] sa, input logic [2:0] p,
        input logic [95:0] wf);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.wstrb = ws; v.ro0 = ro0;
        v.hold = hold; v.stall = stall; v.spm_rd = srd; v.exp_err = err;
        v.exp_rdata = rd; v.exp_lat = lat; v.exp_spm = spm; v.exp_bank = b;
        v.exp_saddr = sa; v.exp_pulse = p; v.exp_wf = wf;
        return v;
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int   cyc;
        int   stall;
        int   pcnt;
        logic pend;
        logic seen;
        logic done;
        logic [2:0] por;
        stall = v.stall;
        pend  = 1'b0;
        seen  = 1'b0;
        done  = 1'b0;
        pcnt  = 0;
        por   = '0;
        cyc   = 0;
        @(negedge clk);
        chk($sformatf("v%0d_req_ready", id), req_ready, 1'b1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        rfile_i   = {RO1, v.ro0};
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            req_valid     = 1'b0;
            spm_rsp_valid = 1'b0;
            spm_req_ready = 1'b0;
            if (wfile_wr_o != '0) pcnt++;
            por |= wfile_wr_o;
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (cyc > 1) chk($sformatf("v%0d_busy_ready", id), req_ready, 1'b0);
                if (pend) begin
                    spm_rsp_valid = 1'b1;
                    spm_rsp_rdata = v.spm_rd;
                    pend = 1'b0;
                end
                if (spm_req_valid) begin
                    seen = 1'b1;
                    chk($sformatf("v%0d_spm_bank", id), spm_bank, v.exp_bank);
                    chk($sformatf("v%0d_spm_addr", id), spm_addr, v.exp_saddr);
                    chk($sformatf("v%0d_spm_we", id), spm_we, v.we);
                    if (v.we) begin
                        chk($sformatf("v%0d_spm_wdata", id), spm_wdata, v.wdata);
                        chk($sformatf("v%0d_spm_wstrb", id), spm_wstrb, v.wstrb);
                    end
                    if (stall == 0) begin
                        spm_req_ready = 1'b1;
                        pend = 1'b1;
                    end else begin
                        stall--;
                    end
                end
            end
        end
        if (!done) begin
            chk($sformatf("v%0d_timeout", id), 1'b0, 1'b1);
            return;
        end
        chk($sformatf("v%0d_latency", id), cyc, v.exp_lat);
        chk($sformatf("v%0d_err", id), rsp_err, v.exp_err);
        chk($sformatf("v%0d_rdata", id), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_forwarded", id), seen, v.exp_spm);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (wfile_wr_o != '0) pcnt++;
            por |= wfile_wr_o;
            chk($sformatf("v%0d_hold_valid", id), rsp_valid, 1'b1);
            chk($sformatf("v%0d_hold_rdata", id), rsp_rdata, v.exp_rdata);
            chk($sformatf("v%0d_hold_err", id), rsp_err, v.exp_err);
            chk($sformatf("v%0d_hold_req_ready", id), req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (wfile_wr_o != '0) pcnt++;
        por |= wfile_wr_o;
        chk($sformatf("v%0d_rsp_drop", id), rsp_valid, 1'b0);
        chk($sformatf("v%0d_idle_ready", id), req_ready, 1'b1);
        chk($sformatf("v%0d_wfile", id), wfile_o, v.exp_wf);
        chk($sformatf("v%0d_pulse", id), por, v.exp_pulse);
        chk($sformatf("v%0d_pulse_len", id), pcnt, (v.exp_pulse != '0) ? 1 : 0);
    endtask

    localparam logic [95:0] WF0 = 96'h0;
    localparam logic [95:0] WFA = {32'h0, 32'h0, 32'hDEADBEEF};
    localparam logic [95:0] WFB = {32'h0, 32'h11223344, 32'hDEADBEEF};
    localparam logic [95:0] WFC = {32'h0, 32'h1122AB44, 32'hDEADBEEF};
    localparam logic [95:0] WFD = {32'hAA0000DD, 32'h1122AB44, 32'hDEADBEEF};

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        fails  = 0;
        vecs[0]  = mk(1, 16'h0400, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 3'b001, WFA);
        vecs[1]  = mk(1, 16'h0404, 32'h11223344, 4'hF, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 3'b010, WFB);
        vecs[2]  = mk(1, 16'h0404, 32'h0000AB00, 4'h2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 3'b010, WFC);
        vecs[3]  = mk(0, 16'h0404, 0, 0, 0, 0, 0, 0, 0, 32'h1122AB44, 2, 0, 0, 0, 0, WFC);
        vecs[4]  = mk(0, 16'h040C, 0, 0, 32'h5A5A, 5, 0, 0, 0, 32'h5A5A, 2, 0, 0, 0, 0, WFC);
        vecs[5]  = mk(0, 16'h0410, 0, 0, 0, 0, 0, 0, 0, RO1, 2, 0, 0, 0, 0, WFC);
        vecs[6]  = mk(0, 16'h0418, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, WFC);
        vecs[7]  = mk(1, 16'h040C, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, WFC);
        vecs[8]  = mk(1, 16'h0408, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, WFC);
        vecs[9]  = mk(1, 16'h0408, 32'hAABBCCDD, 4'h9, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 3'b100, WFD);
        vecs[10] = mk(0, 16'h2404, 0, 0, 0, 0, 0, 0, 0, 32'h1122AB44, 2, 0, 0, 0, 0, WFD);
        vecs[11] = mk(0, 16'h0804, 0, 0, 0, 0, 3, 32'hCAFE, 0, 32'hCAFE, 6, 1, 1, 9'd1, 0, WFD);
        vecs[12] = mk(1, 16'h0008, 32'h55667788, 4'h5, 0, 2, 0, 32'h12345678, 0, 0, 3, 1, 0, 9'd2, 0, WFD);
        vecs[13] = mk(0, 16'h1000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, WFD);
        vecs[14] = mk(0, 16'h1002, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, WFD);
        vecs[15] = mk(1, 16'h0402, 32'hDEADDEAD, 4'hF, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, WFD);

        rst_n = 1'b0;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        rsp_ready = 0; rfile_i = 0; spm_req_ready = 0;
        spm_rsp_valid = 0; spm_rsp_rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_spm_valid", spm_req_valid, 1'b0);
        chk("rst_wfile", wfile_o, WF0);
        chk("rst_wfile_wr", wfile_wr_o, 3'b000);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while the SPM read is outstanding; the late response must vanish.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0804;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rr_spm_valid", spm_req_valid, 1'b1);
        spm_req_ready = 1'b1;
        @(negedge clk);
        spm_req_ready = 1'b0;
        chk("rr_wait_spm_valid", spm_req_valid, 1'b0);
        chk("rr_wait_rsp_valid", rsp_valid, 1'b0);
        chk("rr_wait_req_ready", req_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rr_req_ready", req_ready, 1'b1);
        chk("rr_rsp_valid", rsp_valid, 1'b0);
        chk("rr_spm_valid_rst", spm_req_valid, 1'b0);
        chk("rr_wfile", wfile_o, WF0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        spm_rsp_valid = 1'b1;
        spm_rsp_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        spm_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rr_no_rsp", rsp_valid, 1'b0);
            chk("rr_ready", req_ready, 1'b1);
            @(negedge clk);
        end
        run_vec(99, mk(0, 16'h0400, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, WF0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
